// File: rtl/recovery_lockin_controller.sv
// recovery_lockin_controller: acquire/lock/lose sequencer driving the filter's reference rate and lock-in feedback.
// Define RECOVERY_LOCKIN_TRACKING_EN to let the locked reference follow violation-free events.
package clks_alot_p;
  localparam int RATE_COUNTER_WIDTH = 16;
endpackage

module recovery_lockin_controller #(
  parameter int LOCKIN_THRESHOLD = 4,
  parameter int VIOLATION_LIMIT  = 3
) (
  input  logic                                    clk_i,
  input  logic                                    rst_n_i,
  input  logic                                    enable_i,
  input  logic                                    relock_i,
  input  logic                                    primary_event_i,
  input  logic [clks_alot_p::RATE_COUNTER_WIDTH-1:0] pending_rate_i,
  input  logic                                    positive_drift_violation_i,
  input  logic                                    negative_drift_violation_i,
  output logic [clks_alot_p::RATE_COUNTER_WIDTH-1:0] validated_rate_o,
  output logic                                    rate_locked_in_o,
  output logic                                    rate_counter_clear_o,
  output logic                                    lock_acquired_o,
  output logic                                    lock_lost_o,
  output logic [3:0]                              match_count_o,
  output logic [3:0]                              violation_count_o
);
  localparam int W = clks_alot_p::RATE_COUNTER_WIDTH;
  localparam logic [3:0] THR = 4'(LOCKIN_THRESHOLD);
  localparam logic [3:0] LIM = 4'(VIOLATION_LIMIT);
  typedef enum logic [1:0] {IDLE, SEEK, ACQUIRE, LOCKED} state_t;
  state_t state_q, state_d;
  logic [W-1:0] rate_q, rate_d;
  logic [3:0] match_q, match_d, viol_cnt_q, viol_cnt_d;
  logic acq_q, acq_d, lost_q, lost_d;
  logic viol, timeout, abort;
  assign viol = positive_drift_violation_i | negative_drift_violation_i;
  assign timeout = &pending_rate_i;
  assign abort = ~enable_i | relock_i | timeout;
  assign rate_counter_clear_o = primary_event_i & (state_q != IDLE) & ~abort;
  assign validated_rate_o = rate_q;
  assign rate_locked_in_o = (state_q == LOCKED);
  assign lock_acquired_o = acq_q;
  assign lock_lost_o = lost_q;
  assign match_count_o = match_q;
  assign violation_count_o = viol_cnt_q;
  always_comb begin
    state_d = state_q;
    rate_d = rate_q;
    match_d = match_q;
    viol_cnt_d = viol_cnt_q;
    acq_d = 1'b0;
    lost_d = 1'b0;
    if (!enable_i || relock_i || (timeout && (state_q == ACQUIRE || state_q == LOCKED))) begin
      state_d = enable_i ? SEEK : IDLE;
      rate_d = '0;
      match_d = '0;
      viol_cnt_d = '0;
      lost_d = (state_q == LOCKED);
    end else if (state_q == IDLE) begin
      state_d = SEEK;
    end else if (primary_event_i && !timeout) begin
      // a saturated counter never yields a usable sample, so such events are dropped everywhere
      unique case (state_q)
        SEEK: begin
          state_d = ACQUIRE;
          match_d = '0;
        end
        ACQUIRE: begin
          rate_d = pending_rate_i;
          match_d = (match_q == '0 || viol) ? 4'd1 : match_q + 4'd1;
          if (match_d == THR) begin
            state_d = LOCKED;
            viol_cnt_d = '0;
            acq_d = 1'b1;
          end
        end
        LOCKED: begin
          if (viol) begin
            viol_cnt_d = viol_cnt_q + 4'd1;
            if (viol_cnt_d == LIM) begin
              state_d = ACQUIRE;
              rate_d = pending_rate_i;
              match_d = 4'd1;
              viol_cnt_d = '0;
              lost_d = 1'b1;
            end
          end else begin
            viol_cnt_d = '0;
`ifdef RECOVERY_LOCKIN_TRACKING_EN
            rate_d = pending_rate_i;
`else
            rate_d = rate_q;
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      rate_q <= '0;
      match_q <= '0;
      viol_cnt_q <= '0;
      acq_q <= 1'b0;
      lost_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rate_q <= rate_d;
      match_q <= match_d;
      viol_cnt_q <= viol_cnt_d;
      acq_q <= acq_d;
      lost_q <= lost_d;
    end
  end
endmodule

// File: tb/tb_recovery_lockin_controller.sv
// tb_recovery_lockin_controller: directed stimulus with a pulse scoreboard for lock acquisition/loss.
module tb_recovery_lockin_controller;
  localparam int W = clks_alot_p::RATE_COUNTER_WIDTH;
  logic clk = 0, rst_n = 0, enable = 0, relock = 0, primary = 0, pos = 0, neg = 0;
  logic [W-1:0] pending = 5, vrate;
  logic locked, clr, acq, lost;
  logic [3:0] mc, vc;
  int total = 0, bad = 0;
  typedef struct {logic acq; logic [W-1:0] rate; logic [3:0] mc; logic [3:0] vc; logic lk;} exp_t;
  exp_t q[$];

  recovery_lockin_controller dut (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .relock_i(relock),
    .primary_event_i(primary), .pending_rate_i(pending),
    .positive_drift_violation_i(pos), .negative_drift_violation_i(neg),
    .validated_rate_o(vrate), .rate_locked_in_o(locked), .rate_counter_clear_o(clr),
    .lock_acquired_o(acq), .lock_lost_o(lost), .match_count_o(mc), .violation_count_o(vc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (acq || lost) begin
      if (q.size() == 0) chk("unexpected_pulse", {acq, lost}, 2'b00);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_kind", {acq, lost}, {e.acq, ~e.acq});
        chk("pulse_rate", 32'(vrate), 32'(e.rate));
        chk("pulse_match", 32'(mc), 32'(e.mc));
        chk("pulse_vcount", 32'(vc), 32'(e.vc));
        chk("pulse_locked", 32'(locked), 32'(e.lk));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ev(input logic [W-1:0] r, input logic [1:0] v, input logic exp_clr);
    primary = 1;
    pending = r;
    {pos, neg} = v;
    @(negedge clk);
    chk("rate_counter_clear", 32'(clr), 32'(exp_clr));
    tick();
    primary = 0;
    {pos, neg} = 2'b00;
    pending = 5;
    tick();
  endtask

  task automatic push(input logic a, input logic [W-1:0] r, input logic [3:0] m, input logic [3:0] v, input logic l);
    exp_t e;
    e.acq = a; e.rate = r; e.mc = m; e.vc = v; e.lk = l;
    q.push_back(e);
  endtask

  task automatic acquire_lock(input logic [W-1:0] r);
    ev(r, 2'b00, 1);
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) push(1, r, 4, 0, 1);
      ev(r, 2'b00, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk("reset_rate", 32'(vrate), 0);
    chk("reset_locked", 32'(locked), 0);
    chk("reset_pulses", {acq, lost}, 0);
    chk("reset_counts", {mc, vc}, 0);
    tick();
    rst_n = 1;
    enable = 1;
    tick();
    ev(100, 2'b00, 1);
    chk("seek_start_match", 32'(mc), 0);
    ev(100, 2'b00, 1);
    chk("acq_match1", 32'(mc), 1);
    chk("acq_rate", 32'(vrate), 100);
    ev(100, 2'b00, 1);
    ev(100, 2'b00, 1);
    chk("acq_match3", 32'(mc), 3);
    chk("not_yet_locked", 32'(locked), 0);
    push(1, 100, 4, 0, 1);
    ev(100, 2'b00, 1);
    chk("locked_after", 32'(locked), 1);
    ev(102, 2'b00, 1);
`ifdef RECOVERY_LOCKIN_TRACKING_EN
    chk("tracking_rate", 32'(vrate), 102);
`else
    chk("frozen_rate", 32'(vrate), 100);
`endif
    ev(103, 2'b10, 1);
    chk("vcount1", 32'(vc), 1);
    ev(104, 2'b01, 1);
    chk("vcount2", 32'(vc), 2);
`ifndef RECOVERY_LOCKIN_TRACKING_EN
    chk("viol_holds_rate", 32'(vrate), 100);
`endif
    ev(105, 2'b00, 1);
    chk("clean_resets_vcount", 32'(vc), 0);
    ev(106, 2'b10, 1);
    ev(107, 2'b10, 1);
    push(0, 110, 1, 0, 0);
    ev(110, 2'b01, 1);
    chk("loss_match", 32'(mc), 1);
    ev(110, 2'b00, 1);
    chk("restart_match2", 32'(mc), 2);
    ev(120, 2'b10, 1);
    chk("restart_match1", 32'(mc), 1);
    chk("restart_rate", 32'(vrate), 120);
    ev(121, 2'b00, 1);
    ev(122, 2'b00, 1);
    chk("restart_locked_no", 32'(locked), 0);
    push(1, 123, 4, 0, 1);
    ev(123, 2'b00, 1);
    push(0, 0, 0, 0, 0);
    ev('1, 2'b00, 0);
    chk("timeout_rate", 32'(vrate), 0);
    chk("timeout_unlocked", 32'(locked), 0);
    relock = 1;
    tick();
    relock = 0;
    chk("seek_relock_counts", {mc, vc}, 0);
    acquire_lock(50);
    push(0, 0, 0, 0, 0);
    relock = 1;
    ev(50, 2'b00, 0);
    relock = 0;
    chk("relock_unlocked", 32'(locked), 0);
    acquire_lock(60);
    push(0, 0, 0, 0, 0);
    enable = 0;
    tick();
    chk("disable_unlocked", 32'(locked), 0);
    ev(60, 2'b00, 0);
    enable = 1;
    tick();
    ev(70, 2'b00, 1);
    ev(70, 2'b00, 1);
    ev(70, 2'b00, 1);
    chk("pre_reset_match", 32'(mc), 2);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("async_reset_rate", 32'(vrate), 0);
    chk("async_reset_counts", {mc, vc}, 0);
    chk("async_reset_locked", 32'(locked), 0);
    #1 rst_n = 1;
    tick();
    tick();
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
